pc_sequencer: RTL and testbench

- Parametrised program-counter sequencer for the core fetch stage.
- Holds the PC register and computes the next PC each cycle: sequential increment, PC-relative branch using a sign-extended immediate or a branch-offset LUT, call, and return.
- Contains a writable offset LUT and a return-address stack (RAS) with overflow and underflow detection.
- Sits between instruction decode, which drives the controls, and instruction memory, which is addressed by prog_ctr.

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, relative branch, call/return with a circular RAS.
// Define PC_LUT_WRITE_EN for a writable offset LUT; otherwise the LUT is a constant ROM.
module pc_sequencer #(
  parameter int D         = 12,
  parameter int SEL_W     = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic             immOrLUT,
  input  logic [SEL_W-1:0] pc_ctrl_input,
  input  logic             lut_wr_en,
  input  logic [SEL_W-1:0] lut_wr_addr,
  input  logic [D-1:0]     lut_wr_data,
  output logic [D-1:0]     prog_ctr,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             ras_empty
);

  localparam int PW    = $clog2(RAS_DEPTH);
  localparam int CW    = $clog2(RAS_DEPTH + 1);
  localparam int LUT_N = 2 ** SEL_W;
  localparam logic [D-1:0] NEG5 = ~D'(4);

  function automatic logic [D-1:0] lut_default(input logic [SEL_W-1:0] idx);
    logic [D-1:0] v;
    v = '0;
    if (idx == SEL_W'(0))      v = NEG5;
    else if (idx == SEL_W'(1)) v = D'(20);
    else if (idx == SEL_W'(2)) v = '1;
    return v;
  endfunction

  logic [D-1:0] lut_rd;

`ifdef PC_LUT_WRITE_EN
  logic [D-1:0] lut_q [LUT_N];

  // Writes proceed even while stalled; a same-cycle read sees the old entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= lut_default(SEL_W'(i));
    end else if (lut_wr_en) begin
      lut_q[lut_wr_addr] <= lut_wr_data;
    end
  end

  assign lut_rd = lut_q[pc_ctrl_input];
`else
  logic unused_lut_wr;
  assign unused_lut_wr = ^{lut_wr_en, lut_wr_addr, lut_wr_data};
  assign lut_rd = lut_default(pc_ctrl_input);
`endif

  logic [D-1:0]  pc_q, pc_d;
  logic [D-1:0]  ras_q [RAS_DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push;
  logic [D-1:0]  pc_inc, offset, pc_tgt;
  logic          ras_full, ras_none;

  assign pc_inc   = pc_q + D'(1);
  assign offset   = immOrLUT ? lut_rd
                             : {{(D-SEL_W){pc_ctrl_input[SEL_W-1]}}, pc_ctrl_input};
  assign pc_tgt   = pc_q + offset;
  assign ras_full = (count_q == CW'(RAS_DEPTH));
  assign ras_none = (count_q == '0);

  // Priority: stall > ret > call > branch > increment.
  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (!ras_none) begin
          pc_d    = ras_q[top_q];
          top_d   = top_q - PW'(1);
          count_d = count_q - CW'(1);
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (call) begin
        push  = 1'b1;
        top_d = top_q + PW'(1);
        pc_d  = pc_tgt;
        // When full the new top slot is the oldest entry, so it is overwritten.
        if (ras_full) ovf_d = 1'b1;
        else          count_d = count_q + CW'(1);
      end else if (branch) begin
        pc_d = pc_tgt;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q    <= '0;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (push) ras_q[top_d] <= pc_inc;
    end
  end

  assign prog_ctr      = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign ras_empty     = ras_none;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, checked against a
// queue-based reference model through an expected-response scoreboard.
module tb_pc_sequencer;

  localparam int D         = 12;
  localparam int SEL_W     = 4;
  localparam int RAS_DEPTH = 4;
  localparam int MASK      = (1 << D) - 1;
  localparam int W         = D + 3;

  logic             Clk;
  logic             Reset;
  logic             stall, branch, call, ret, immOrLUT;
  logic [SEL_W-1:0] pc_ctrl_input;
  logic             lut_wr_en;
  logic [SEL_W-1:0] lut_wr_addr;
  logic [D-1:0]     lut_wr_data;
  logic [D-1:0]     prog_ctr;
  logic             ras_overflow, ras_underflow, ras_empty;

  pc_sequencer #(.D(D), .SEL_W(SEL_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .stall(stall), .branch(branch), .call(call), .ret(ret),
    .immOrLUT(immOrLUT), .pc_ctrl_input(pc_ctrl_input), .lut_wr_en(lut_wr_en),
    .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data), .prog_ctr(prog_ctr),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .ras_empty(ras_empty)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: PC as an integer, RAS as a bounded queue, LUT as an int array.
  int m_pc;
  int m_ras[$];
  bit m_ovf, m_unf;
  int m_lut[2**SEL_W];

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    m_pc = 0;
    m_ras.delete();
    m_ovf = 0;
    m_unf = 0;
    for (int i = 0; i < 2**SEL_W; i++) m_lut[i] = 0;
    m_lut[0] = (-5) & MASK;
    m_lut[1] = 20;
    m_lut[2] = (-1) & MASK;
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [D-1:0] p;
    p = D'(m_pc & MASK);
    return {p, (m_ras.size() == 0), m_ovf, m_unf};
  endfunction

  // Driver: apply one cycle of controls, advance the model, queue the expectation.
  task automatic step(input bit rst, input bit st, input bit br, input bit ca, input bit re,
                      input bit im, input logic [SEL_W-1:0] sel, input bit we,
                      input logic [SEL_W-1:0] wa, input logic [D-1:0] wd);
    int off;
    @(negedge Clk);
    Reset = rst; stall = st; branch = br; call = ca; ret = re; immOrLUT = im;
    pc_ctrl_input = sel; lut_wr_en = we; lut_wr_addr = wa; lut_wr_data = wd;
    if (im) off = m_lut[sel];
    else begin
      off = int'(sel);
      if (sel[SEL_W-1]) off -= (1 << SEL_W);
    end
    if (rst) model_reset();
    else begin
      if (!st) begin
        if (re) begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else begin m_pc = (m_pc + 1) & MASK; m_unf = 1; end
        end else if (ca) begin
          m_ras.push_back((m_pc + 1) & MASK);
          if (m_ras.size() > RAS_DEPTH) begin void'(m_ras.pop_front()); m_ovf = 1; end
          m_pc = (m_pc + off) & MASK;
        end else if (br) m_pc = (m_pc + off) & MASK;
        else m_pc = (m_pc + 1) & MASK;
      end
`ifdef PC_LUT_WRITE_EN
      if (we) m_lut[wa] = int'(wd);
`endif
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic t_reset();                       step(1,0,0,0,0,0,0,0,0,0); endtask
  task automatic t_idle();                        step(0,0,0,0,0,0,0,0,0,0); endtask
  task automatic t_stall();                       step(0,1,0,0,0,0,0,0,0,0); endtask
  task automatic t_ret();                         step(0,0,0,0,1,0,0,0,0,0); endtask
  task automatic t_branch(input bit im, input logic [SEL_W-1:0] s); step(0,0,1,0,0,im,s,0,0,0); endtask
  task automatic t_call(input bit im, input logic [SEL_W-1:0] s);   step(0,0,0,1,0,im,s,0,0,0); endtask

  // Monitor: one registered response per edge, compared against the queue head.
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {prog_ctr, ras_empty, ras_overflow, ras_underflow};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_check t=%0t: pc=%h empty=%b ovf=%b unf=%b, expected pc=%h empty=%b ovf=%b unf=%b",
                   $time, a[W-1:3], a[2], a[1], a[0], e[W-1:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int k;
    Reset = 1'b1; stall = 0; branch = 0; call = 0; ret = 0; immOrLUT = 0;
    pc_ctrl_input = '0; lut_wr_en = 0; lut_wr_addr = '0; lut_wr_data = '0;
    model_reset();

    // Reset values, then 1,2,3
    t_reset(); t_reset();
    repeat (3) t_idle();

    // Immediate and LUT branches from PC=10: 8, 28, 23
    t_reset();
    repeat (10) t_idle();
    t_branch(0, 4'b1110);
    t_branch(1, 4'd1);
    t_branch(1, 4'd0);

    // Wrap both directions
    t_reset();
    t_branch(0, 4'hF);
    t_idle();

    // Call / stall / return / underflow
    t_reset();
    repeat (5) t_idle();
    t_call(0, 4'd3);
    t_stall(); t_stall();
    t_ret();
    t_ret();

    // Overflow then drain the RAS past empty
    t_reset();
    repeat (16) t_idle();
    repeat (5) t_call(0, 4'd7);
    repeat (5) t_ret();

    // Simultaneous controls: ret+call, call+branch
    t_reset();
    step(0,0,1,1,0,0,4'd5,0,0,0);
    step(0,0,0,1,1,0,4'd5,0,0,0);

    // LUT write collides with a read of the same index
    t_reset();
    repeat (10) t_idle();
    step(0,0,1,0,0,1,4'd3,1,4'd3,D'(100));
    t_branch(1, 4'd3);
    step(0,1,0,0,0,0,0,1,4'd0,D'(7));
    t_branch(1, 4'd0);
    // Mid-run reset restores LUT defaults
    t_reset();
    t_branch(1, 4'd3);
    t_branch(1, 4'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
           r < 30, (r >= 30 && r < 50) || $urandom_range(0, 19) == 0,
           r >= 50 && r < 70, $urandom_range(0, 1) == 1,
           SEL_W'($urandom_range(0, 15)), $urandom_range(0, 4) == 0,
           SEL_W'($urandom_range(0, 15)), D'($urandom_range(0, MASK)));
    end

    @(negedge Clk);
    Reset = 0; stall = 1; branch = 0; call = 0; ret = 0; lut_wr_en = 0;
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin @(posedge Clk); k++; end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
